// File: rtl/mem_stage_unit.sv
// MEM stage: runs loads/stores on a req/ack data memory and loads the MEM/WB register.
// Non-memory ops take one cycle. Memory ops hold freeze high until the access completes or times out.
module mem_stage_unit #(
   parameter logic [31:0] MEM_BASE = 32'd1024,
   parameter logic [7:0]  TIMEOUT  = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC_in,
   input  logic        WB_En_in,
   input  logic        MEM_R_En_in,
   input  logic        MEM_W_En_in,
   input  logic [31:0] ALU_result_in,
   input  logic [31:0] Store_val_in,
   output logic        freeze,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] PC,
   output logic        WB_En,
   output logic        MEM_R_En,
   output logic [31:0] ALU_result,
   output logic [31:0] Mem_value,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic        abort;
   logic [31:0] rdata_q;
   logic [31:0] addr_diff;
   logic        mem_op, is_load, misaligned, timed_out;

   assign mem_op     = MEM_R_En_in | MEM_W_En_in;
   // A simultaneous read and write request is executed as a store.
   assign is_load    = MEM_R_En_in & ~MEM_W_En_in;
   assign misaligned = (ALU_result_in[1:0] != 2'b00);
   assign timed_out  = (cnt == (TIMEOUT - 8'd1));
   assign addr_diff  = ALU_result_in - MEM_BASE;
   assign mem_addr   = {2'b00, addr_diff[31:2]};
   assign mem_wdata  = Store_val_in;

   always_comb begin
      state_nxt = state;
      freeze    = 1'b0;
      case (state)
         IDLE: begin
            if (mem_op && !misaligned) begin
               freeze    = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            freeze = 1'b1;
            if (mem_ack || timed_out)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (rst)
         freeze = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         abort      <= 1'b0;
         rdata_q    <= 32'd0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         PC         <= 32'd0;
         WB_En      <= 1'b0;
         MEM_R_En   <= 1'b0;
         ALU_result <= 32'd0;
         Mem_value  <= 32'd0;
         bus_err    <= 1'b0;
      end else begin
         state   <= state_nxt;
         mem_req <= (state_nxt == ACCESS);
         mem_we  <= (state_nxt == ACCESS) & MEM_W_En_in;
         cnt     <= (state == ACCESS) ? cnt + 8'd1 : 8'd0;

         if (state == ACCESS) begin
            if (mem_ack) begin
               abort   <= 1'b0;
               rdata_q <= is_load ? mem_rdata : 32'd0;
            end else if (timed_out) begin
               abort   <= 1'b1;
               rdata_q <= 32'd0;
            end
         end

         // Default is a bubble; only completing instructions overwrite it.
         PC         <= 32'd0;
         WB_En      <= 1'b0;
         MEM_R_En   <= 1'b0;
         ALU_result <= 32'd0;
         Mem_value  <= 32'd0;
         bus_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (!mem_op || misaligned) begin
                  PC         <= PC_in;
                  ALU_result <= ALU_result_in;
                  WB_En      <= WB_En_in & ~mem_op;
                  bus_err    <= mem_op;
               end
            end
            DONE: begin
               PC         <= PC_in;
               WB_En      <= WB_En_in & ~abort;
               MEM_R_En   <= is_load;
               ALU_result <= ALU_result_in;
               Mem_value  <= rdata_q;
               bus_err    <= abort;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: expected MEM/WB contents are queued when an
// instruction is driven and compared when the stage releases freeze and loads MEM/WB.
module tb_mem_stage_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in, alu_in, sv_in, rdata;
   logic        wb_in, r_in, w_in;
   logic        ack_m, ack_t;

   logic        m_freeze, m_req, m_we, m_wb, m_r, m_err;
   logic [31:0] m_addr, m_wdata, m_pc, m_alu, m_mv;
   logic        t_freeze, t_req, t_we, t_wb, t_r, t_err;
   logic [31:0] t_addr, t_wdata, t_pc, t_alu, t_mv;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] pc;
      logic        wb;
      logic        r;
      logic [31:0] alu;
      logic [31:0] mv;
      logic        err;
      int          fcyc;
      int          rcyc;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   mem_stage_unit dut (
      .clk(clk), .rst(rst), .PC_in(pc_in), .WB_En_in(wb_in), .MEM_R_En_in(r_in),
      .MEM_W_En_in(w_in), .ALU_result_in(alu_in), .Store_val_in(sv_in),
      .freeze(m_freeze), .mem_req(m_req), .mem_we(m_we), .mem_addr(m_addr),
      .mem_wdata(m_wdata), .mem_rdata(rdata), .mem_ack(ack_m), .PC(m_pc),
      .WB_En(m_wb), .MEM_R_En(m_r), .ALU_result(m_alu), .Mem_value(m_mv), .bus_err(m_err)
   );

   mem_stage_unit #(.MEM_BASE(32'd1024), .TIMEOUT(8'd4)) dut_to (
      .clk(clk), .rst(rst), .PC_in(pc_in), .WB_En_in(wb_in), .MEM_R_En_in(r_in),
      .MEM_W_En_in(w_in), .ALU_result_in(alu_in), .Store_val_in(sv_in),
      .freeze(t_freeze), .mem_req(t_req), .mem_we(t_we), .mem_addr(t_addr),
      .mem_wdata(t_wdata), .mem_rdata(rdata), .mem_ack(ack_t), .PC(t_pc),
      .WB_En(t_wb), .MEM_R_En(t_r), .ALU_result(t_alu), .Mem_value(t_mv), .bus_err(t_err)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // sel=0 observes the TIMEOUT=255 instance, sel=1 the TIMEOUT=4 instance.
   // ack_dly: ACCESS cycle index (0 = first) carrying mem_ack, -1 for none.
   task automatic run_instr(input bit sel, input logic [31:0] pc, input bit wb, input bit r,
                            input bit w, input logic [31:0] alu, input logic [31:0] sv,
                            input logic [31:0] rd, input int ack_dly, input int to);
      exp_t e, got;
      bit mem_op, mis, acked, load, done;
      int fc, rc;
      logic [31:0] exp_addr;
      mem_op = r | w;
      mis    = mem_op && (alu[1:0] != 2'b00);
      load   = r && !w;
      acked  = (ack_dly >= 0) && (ack_dly < to);
      exp_addr = (alu - 32'd1024) >> 2;
      if (!mem_op) begin
         e = '{pc, wb, 1'b0, alu, 32'd0, 1'b0, 0, 0};
      end else if (mis) begin
         e = '{pc, 1'b0, 1'b0, alu, 32'd0, 1'b1, 0, 0};
      end else begin
         e.pc = pc; e.r = load; e.alu = alu;
         e.wb   = wb && acked;
         e.mv   = (load && acked) ? rd : 32'd0;
         e.err  = !acked;
         e.fcyc = acked ? ack_dly + 2 : to + 1;
         e.rcyc = acked ? ack_dly + 1 : to;
      end
      sb_q.push_back(e);

      pc_in = pc; wb_in = wb; r_in = r; w_in = w; alu_in = alu; sv_in = sv; rdata = rd;
      fc = 0; rc = 0; done = 0;
      for (int cyc = 0; cyc < 600 && !done; cyc++) begin
         @(negedge clk);
         if (sel ? t_req : m_req) begin
            rc++;
            if (rc == 1) begin
               check_val("mem_addr", sel ? t_addr : m_addr, exp_addr);
               check_val("mem_we", {31'd0, sel ? t_we : m_we}, {31'd0, w});
               check_val("mem_wdata", sel ? t_wdata : m_wdata, sv);
               check_val("bubble_pc", sel ? t_pc : m_pc, 32'd0);
            end
            if (sel) ack_t = (rc - 1 == ack_dly);
            else     ack_m = (rc - 1 == ack_dly);
         end else begin
            ack_m = 1'b0; ack_t = 1'b0;
         end
         if (sel ? t_freeze : m_freeze) fc++;
         else done = 1;
      end
      check_val("completed", {31'd0, done}, 32'd1);
      @(posedge clk); #1;
      ack_m = 1'b0; ack_t = 1'b0;

      got = sb_q.pop_front();
      check_val("freeze_cycles", fc, got.fcyc);
      check_val("req_cycles", rc, got.rcyc);
      check_val("PC", sel ? t_pc : m_pc, got.pc);
      check_val("WB_En", {31'd0, sel ? t_wb : m_wb}, {31'd0, got.wb});
      check_val("ALU_result", sel ? t_alu : m_alu, got.alu);
      check_val("Mem_value", sel ? t_mv : m_mv, got.mv);
      check_val("bus_err", {31'd0, sel ? t_err : m_err}, {31'd0, got.err});
      if (!got.err || !mem_op)
         check_val("MEM_R_En", {31'd0, sel ? t_r : m_r}, {31'd0, got.r});
   endtask

   initial begin
      rst = 1'b1; ack_m = 1'b0; ack_t = 1'b0;
      pc_in = 32'h40; wb_in = 1'b1; r_in = 1'b1; w_in = 1'b0;
      alu_in = 32'd1028; sv_in = 32'd0; rdata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_freeze", {31'd0, m_freeze}, 32'd0);
      check_val("rst_req", {31'd0, m_req}, 32'd0);
      check_val("rst_pc", m_pc, 32'd0);
      check_val("rst_wb", {31'd0, m_wb}, 32'd0);
      check_val("rst_err", {31'd0, m_err}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; r_in = 1'b0; wb_in = 1'b0; alu_in = 32'd0; pc_in = 32'd0;

      run_instr(0, 32'h100, 1, 0, 0, 32'h2A,     32'h0,    32'h1234,     -1, 255);
      run_instr(0, 32'h104, 1, 1, 0, 32'd1028,   32'h0,    32'hDEADBEEF,  0, 255);
      run_instr(0, 32'h108, 0, 0, 1, 32'd1032,   32'h55,   32'hFFFF0000,  4, 255);
      run_instr(0, 32'h10C, 0, 1, 1, 32'd1036,   32'hA5A5, 32'h77,        2, 255);
      run_instr(0, 32'h110, 1, 1, 0, 32'd1025,   32'h0,    32'h0,        -1, 255);
      run_instr(0, 32'h114, 0, 0, 1, 32'd1030,   32'h9,    32'h0,        -1, 255);
      run_instr(0, 32'h118, 1, 1, 0, 32'd0,      32'h0,    32'hCAFE0001,  1, 255);
      run_instr(0, 32'h11C, 0, 0, 0, 32'hFFFF,   32'h0,    32'h0,        -1, 255);

      // Reset in the second ACCESS cycle, late ack on the following cycle.
      pc_in = 32'h300; wb_in = 1'b1; r_in = 1'b1; w_in = 1'b0; alu_in = 32'd1044; rdata = 32'h1111;
      @(negedge clk);
      @(negedge clk);
      check_val("r6_req", {31'd0, m_req}, 32'd1);
      @(negedge clk);
      rst = 1'b1; #1;
      check_val("r6_freeze_rst", {31'd0, m_freeze}, 32'd0);
      @(posedge clk); #1;
      check_val("r6_req_after", {31'd0, m_req}, 32'd0);
      check_val("r6_pc", m_pc, 32'd0);
      check_val("r6_wb", {31'd0, m_wb}, 32'd0);
      rst = 1'b0; ack_m = 1'b1;
      pc_in = 32'h304; r_in = 1'b0; alu_in = 32'h77; #1;
      check_val("r6_freeze_idle", {31'd0, m_freeze}, 32'd0);
      @(posedge clk); #1;
      ack_m = 1'b0;
      check_val("r6_alu_pc", m_pc, 32'h304);
      check_val("r6_alu_wb", {31'd0, m_wb}, 32'd1);
      check_val("r6_alu_val", m_alu, 32'h77);
      check_val("r6_alu_err", {31'd0, m_err}, 32'd0);
      check_val("r6_alu_req", {31'd0, m_req}, 32'd0);

      // Resynchronise both instances, then exercise the TIMEOUT=4 one.
      r_in = 1'b0; w_in = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      run_instr(1, 32'h200, 1, 1, 0, 32'd1040, 32'h0, 32'h99, -1, 4);
      run_instr(1, 32'h204, 1, 1, 0, 32'd1048, 32'h0, 32'h5A5A5A5A, 3, 4);
      run_instr(1, 32'h208, 1, 0, 0, 32'h1, 32'h0, 32'h0, -1, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
